// File: rtl/vector_seq_gen.sv
// vector_seq_gen: start-triggered beat sequencer with valid/ready handshake driving the vector block inputs
module vector_seq_gen #(
  parameter int NUM_STEPS  = 20,
  parameter int SHIFT_WRAP = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [3:0]  vector_0_o,
  output logic        scala_1_o,
  output logic [12:0] vector_2_o,
  output logic [3:0]  vector_3_o_0,
  output logic [3:0]  vector_3_o_1,
  output logic [3:0]  vector_3_o_2,
  output logic [3:0]  shift_cnt_o,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t     r_state;
  logic [4:0] r_k;
  logic [3:0] r_shift;
  logic [4:0] w_k_nxt;
  logic [3:0] w_sh_nxt;
  logic       w_accept, w_last, w_load, w_finish;
  // next beat: first beat of a run from IDLE, otherwise advance k and the wrapping shift
  always_comb begin
    w_accept = out_valid & out_ready;
    w_last   = r_k == 5'(NUM_STEPS);
    w_k_nxt  = (r_state == RUN) ? r_k + 5'd1 : 5'd1;
    w_sh_nxt = (r_state != RUN) ? 4'd0 : (r_shift == 4'(SHIFT_WRAP)) ? 4'd0 : r_shift + 4'd1;
    w_load   = (r_state == IDLE) ? (start & ~stop) : (r_state == RUN) & ~stop & w_accept & ~w_last;
    w_finish = (r_state == RUN) & ~stop & w_accept & w_last;
  end
  // state, beat counters and registered outputs; data only moves on load, otherwise holds or clears
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_k          <= '0;
      r_shift      <= '0;
      out_valid    <= 1'b0;
      vector_0_o   <= '0;
      scala_1_o    <= 1'b0;
      vector_2_o   <= '0;
      vector_3_o_0 <= '0;
      vector_3_o_1 <= '0;
      vector_3_o_2 <= '0;
      shift_cnt_o  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      r_state <= w_load ? RUN : w_finish ? DONE : (r_state == RUN && !stop) ? RUN : IDLE;
      busy    <= w_load | ((r_state == RUN) & ~stop & ~w_finish);
      done    <= w_finish;
      if (w_load) begin
        r_k          <= w_k_nxt;
        r_shift      <= w_sh_nxt;
        out_valid    <= 1'b1;
        vector_0_o   <= w_k_nxt[3:0];
        scala_1_o    <= w_k_nxt[0];
        vector_2_o   <= 13'd1 << w_sh_nxt;
        vector_3_o_0 <= w_sh_nxt;
        vector_3_o_1 <= w_sh_nxt + 4'd1;
        vector_3_o_2 <= w_sh_nxt + 4'd2;
        shift_cnt_o  <= w_sh_nxt;
      end else if (r_state != RUN || stop || w_finish) begin
        r_k          <= '0;
        r_shift      <= '0;
        out_valid    <= 1'b0;
        vector_0_o   <= '0;
        scala_1_o    <= 1'b0;
        vector_2_o   <= '0;
        vector_3_o_0 <= '0;
        vector_3_o_1 <= '0;
        vector_3_o_2 <= '0;
        shift_cnt_o  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_vector_seq_gen.sv
// tb_vector_seq_gen: directed checks of run sequencing, stalls, abort, ignored controls and async reset
module tb_vector_seq_gen;
  logic        clk = 0, rst = 1, start = 0, stop = 0, out_ready = 0;
  logic        out_valid, scala_1_o, busy, done;
  logic [3:0]  vector_0_o, vector_3_o_0, vector_3_o_1, vector_3_o_2, shift_cnt_o;
  logic [12:0] vector_2_o;
  int          tests = 0, fails = 0;

  vector_seq_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .out_ready(out_ready),
    .out_valid(out_valid), .vector_0_o(vector_0_o), .scala_1_o(scala_1_o),
    .vector_2_o(vector_2_o), .vector_3_o_0(vector_3_o_0), .vector_3_o_1(vector_3_o_1),
    .vector_3_o_2(vector_3_o_2), .shift_cnt_o(shift_cnt_o), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_data"}, {vector_0_o, scala_1_o, vector_2_o, vector_3_o_0, vector_3_o_1, vector_3_o_2, shift_cnt_o}, 0);
  endtask

  task automatic chk_beat(input int k);
    int sh;
    sh = (k - 1) % 13;
    chk($sformatf("b%0d_valid", k), out_valid, 1);
    chk($sformatf("b%0d_busy", k), busy, 1);
    chk($sformatf("b%0d_done", k), done, 0);
    chk($sformatf("b%0d_v0", k), vector_0_o, k % 16);
    chk($sformatf("b%0d_s1", k), scala_1_o, k % 2);
    chk($sformatf("b%0d_sh", k), shift_cnt_o, sh);
    chk($sformatf("b%0d_v2", k), vector_2_o, 1 << sh);
    chk($sformatf("b%0d_v3", k), {vector_3_o_0, vector_3_o_1, vector_3_o_2}, {4'(sh), 4'(sh + 1), 4'(sh + 2)});
  endtask

  task automatic begin_run();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic run_beats(input int from, input int to);
    out_ready = 1;
    for (int k = from; k <= to; k++) begin
      chk_beat(k);
      tick();
    end
  endtask

  task automatic chk_end(input string tag);
    chk_idle({tag, "_donepulse"}, 1);
    tick();
    chk_idle({tag, "_after"}, 0);
  endtask

  initial begin
    #12 rst = 0;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk_idle("reset", 0);
      tick();
    end

    out_ready = 1;
    begin_run();
    chk("t2_b1_v0", vector_0_o, 4'd1);
    chk("t2_b1_v2", vector_2_o, 13'h0001);
    chk("t2_b1_v3", {vector_3_o_0, vector_3_o_1, vector_3_o_2}, 12'h012);
    for (int k = 1; k <= 20; k++) begin
      if (k == 13) begin
        chk("t2_b13_v2", vector_2_o, 13'h1000);
        chk("t2_b13_v3", {vector_3_o_0, vector_3_o_1, vector_3_o_2}, 12'hCDE);
      end
      if (k == 14) begin
        chk("t2_b14_sh", shift_cnt_o, 4'd0);
        chk("t2_b14_v2", vector_2_o, 13'h0001);
      end
      if (k == 16) chk("t2_b16_v0", vector_0_o, 4'd0);
      chk_beat(k);
      tick();
    end
    chk_end("t2");

    begin_run();
    run_beats(1, 2);
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_v0", vector_0_o, 4'd3);
      chk("t3_hold_v2", vector_2_o, 13'h0004);
      chk_beat(3);
      tick();
    end
    run_beats(3, 20);
    chk_end("t3");

    begin_run();
    run_beats(1, 6);
    chk_beat(7);
    stop = 1;
    tick();
    stop = 0;
    for (int i = 0; i < 4; i++) begin
      chk_idle("t4_abort", 0);
      tick();
    end
    begin_run();
    chk_beat(1);
    run_beats(1, 20);
    chk_end("t4_rerun");

    begin_run();
    run_beats(1, 1);
    start = 1;
    tick();
    start = 0;
    chk_beat(3);
    run_beats(3, 20);
    start = 1;
    chk_idle("t5_done_start", 1);
    tick();
    start = 0;
    chk_idle("t5_done_ignored", 0);
    start = 1;
    stop = 1;
    tick();
    chk_idle("t5_startstop", 0);
    tick();
    start = 0;
    stop = 0;
    chk_idle("t5_startstop2", 0);

    begin_run();
    run_beats(1, 9);
    chk_beat(10);
    #2 rst = 1;
    #1 chk_idle("t6_async", 0);
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      chk_idle("t6_after", 0);
      tick();
    end
    begin_run();
    chk_beat(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
